i2s_tx_stereo: RTL



---
 rtl/i2s_tx_stereo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified transmitter with a small sample-pair FIFO.
// The bit clock is divided down from the system clock; frames start with a pop (or an underrun).
module i2s_tx_stereo #(
   parameter int SAMPLE_W   = 16,
   parameter int CLK_DIV    = 25,
   parameter int FIFO_DEPTH = 4,
   parameter int PHILIPS    = 1
) (
   input  logic                clock,
   input  logic                reset_l,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] left_sample,
   input  logic [SAMPLE_W-1:0] right_sample,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                clr_underrun,
   output logic                underrun,
   output logic                i2s_bclk,
   output logic                i2s_ws,
   output logic                i2s_sd
);

   localparam int FRAME_W = 2 * SAMPLE_W;
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int SLOT_W  = $clog2(FRAME_W);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_W - 1);
   localparam logic [SLOT_W-1:0] RIGHT_1ST = SLOT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   logic [DIV_W-1:0]   div_cnt;
   logic [SLOT_W-1:0]  slot;
   logic [FRAME_W-1:0] frame;
   logic               saved_lsb;

   logic [FRAME_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   logic               div_wrap;
   logic               fall;
   logic               load;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [SLOT_W-1:0]  next_slot;
   logic [SLOT_W-1:0]  sd_idx;
   logic [FRAME_W-1:0] cur_frame;
   logic               sd_next;
   logic [CNT_W-1:0]   count_next;

   // divider wrap, fall event, frame load and the bit presented in the next slot
   always_comb begin
      div_wrap   = enable && (div_cnt == DIV_LAST);
      fall       = div_wrap && i2s_bclk;
      load       = fall && (slot == LAST_SLOT);
      fifo_empty = (count == CNT_W'(0));
      push       = in_valid && in_ready;
      pop        = load && !fifo_empty;
      if (slot == LAST_SLOT) begin
         next_slot = SLOT_W'(0);
      end else begin
         next_slot = slot + SLOT_W'(1);
      end
      if (load) begin
         cur_frame = fifo_empty ? FRAME_W'(0) : mem[rd_ptr];
      end else begin
         cur_frame = frame;
      end
      // Philips mode presents each bit one slot late; slot 0 replays the saved right LSB
      sd_idx  = LAST_SLOT - next_slot;
      sd_next = 1'b0;
      if (PHILIPS != 0) begin
         if (next_slot == SLOT_W'(0)) begin
            sd_next = saved_lsb;
         end else begin
            sd_next = cur_frame[sd_idx + SLOT_W'(1)];
         end
      end else begin
         sd_next = cur_frame[sd_idx];
      end
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // serial side: divider, slot counter, frame register and pin registers
   always_ff @(posedge clock) begin
      if (!reset_l || !enable) begin
         div_cnt   <= DIV_W'(0);
         slot      <= LAST_SLOT;
         frame     <= FRAME_W'(0);
         saved_lsb <= 1'b0;
         i2s_bclk  <= 1'b0;
         i2s_ws    <= 1'b0;
         i2s_sd    <= 1'b0;
      end else begin
         if (div_wrap) begin
            div_cnt  <= DIV_W'(0);
            i2s_bclk <= ~i2s_bclk;
         end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
         end
         if (fall) begin
            slot   <= next_slot;
            frame  <= cur_frame;
            i2s_ws <= (next_slot >= RIGHT_1ST);
            i2s_sd <= sd_next;
            if (next_slot == LAST_SLOT) begin
               saved_lsb <= cur_frame[0];
            end
         end
      end
   end

   // sticky underrun; a new underrun wins over a simultaneous clear
   always_ff @(posedge clock) begin
      if (!reset_l) begin
         underrun <= 1'b0;
      end else if (load && fifo_empty) begin
         underrun <= 1'b1;
      end else if (clr_underrun) begin
         underrun <= 1'b0;
      end
   end

   // FIFO pointers, occupancy and ready flag
   always_ff @(posedge clock) begin
      if (!reset_l) begin
         wr_ptr   <= PTR_W'(0);
         rd_ptr   <= PTR_W'(0);
         count    <= CNT_W'(0);
         in_ready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count    <= count_next;
         in_ready <= (count_next != FULL_CNT);
      end
   end

   // FIFO storage, left sample in the upper half
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {left_sample, right_sample};
      end
   end

endmodule
